aesl_deadlock_monitor_param: RTL and testbench

- Parametrised dataflow deadlock monitor for C/RTL cosimulation.
- Watches NUM_PROC dataflow processes and NUM_AXIS AXI-Stream channels, with each channel mapped to its owning process.
- Declares deadlock only after a global stall persists for CONFIRM_CYCLES consecutive cycles, then latches a per-channel culprit snapshot and counts stall duration.
- Instantiated once per dataflow region by the cosim top; successor to the fixed 5-process/2-channel monitor.

---
 rtl/aesl_deadlock_monitor_param.sv | 223 ++++++++++++++++++++++
 tb/tb_aesl_deadlock_monitor_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aesl_deadlock_monitor_param.sv
//-----------------------------------------------------------------------------
// aesl_deadlock_monitor_param
//
// Dataflow deadlock monitor used in C/RTL cosimulation. There is one instance
// per dataflow region. It watches NUM_PROC dataflow processes and NUM_AXIS
// AXI-Stream channels. Each channel belongs to one process.
//
// The monitor declares a deadlock only after a global stall has lasted
// CONFIRM_CYCLES consecutive cycles. A global stall means:
//   - every process is idle, FIFO-blocked, or owns a blocked AXIS channel, and
//   - at least one AXIS channel is blocked.
//
// When the deadlock is declared, the monitor:
//   - latches a per-channel culprit snapshot, and
//   - counts how long the stall lasts.
//
// Parameters:
//   NUM_PROC       number of dataflow processes (1..64)
//   NUM_AXIS       number of monitored AXIS channels (1..32)
//   AXIS_PROC_MAP  8 bits per channel; field c is the owning process of
//                  channel c. A field >= NUM_PROC detaches that channel.
//   CONFIRM_CYCLES consecutive stalled cycles required before block (>=1)
//   STICKY         1: block held until clear/reset; 0: drops when stall ends
//   CNT_W          width of stall_cnt
//
// Ports:
//   clock            sole clock, rising edge
//   reset            synchronous, active-high, full register reset
//   clear            synchronous clear of the latched deadlock state
//   axis_block_sigs  [NUM_AXIS]   per-channel AXIS blocked
//   inst_idle_sigs   [NUM_PROC]   per-process idle
//   inst_block_sigs  [NUM_PROC]   per-process FIFO/channel blocked
//   axis_block_info  [2*NUM_AXIS] culprit snapshot, 2 bits per channel:
//                                 11 primary (lowest blocked), 01 blocked,
//                                 00 clear; all zero unless block=1
//   block            deadlock declared
//   stall_cnt        [CNT_W]      cycles spent deadlocked, saturating
//
// All outputs come straight from registers. There is no input-to-output
// combinational path.
//-----------------------------------------------------------------------------
module aesl_deadlock_monitor_param #(
  parameter int                    NUM_PROC       = 5,
  parameter int                    NUM_AXIS       = 2,
  parameter logic [8*NUM_AXIS-1:0] AXIS_PROC_MAP  = {8'd4, 8'd1},
  parameter int                    CONFIRM_CYCLES = 1,
  parameter bit                    STICKY         = 1'b1,
  parameter int                    CNT_W          = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [NUM_AXIS-1:0]   axis_block_sigs,
  input  logic [NUM_PROC-1:0]   inst_idle_sigs,
  input  logic [NUM_PROC-1:0]   inst_block_sigs,
  output logic [2*NUM_AXIS-1:0] axis_block_info,
  output logic                  block,
  output logic [CNT_W-1:0]      stall_cnt
);

  // The run counter only ever holds 0..CONFIRM_CYCLES-1.
  localparam int RUN_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*NUM_AXIS-1:0] snap_q, snap_d;
  logic                  block_q, block_d;

  logic [NUM_PROC-1:0]   axis_vec;
  logic [NUM_PROC-1:0]   stopped;
  logic                  stop_now;
  logic [2*NUM_AXIS-1:0] snap_new;
  logic                  found;

  //---------------------------------------------------------------------------
  // Fold the AXIS channels onto their owning processes.
  //
  // A channel whose map entry is >= NUM_PROC never matches any process index,
  // so it drops out of the stall decision.
  //---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    axis_vec = '0;
    for (int p = 0; p < NUM_PROC; p++) begin
      for (int c = 0; c < NUM_AXIS; c++) begin
        if (int'(AXIS_PROC_MAP[8*c +: 8]) == p) begin
          axis_vec[p] = axis_vec[p] | axis_block_sigs[c];
        end
      end
    end
  end

  assign stopped = inst_idle_sigs | inst_block_sigs | axis_vec;

  // An all-idle region is a finished region, not a deadlock.
  // At least one AXIS block has to take part.
  assign stop_now = (|axis_vec) & (&stopped);

  //---------------------------------------------------------------------------
  // Culprit snapshot candidate.
  //
  // The lowest-index blocked channel is marked as primary (11).
  // Every other blocked channel is marked 01.
  //---------------------------------------------------------------------------
  always_comb begin
    snap_new = '0;
    found    = 1'b0;
    for (int c = 0; c < NUM_AXIS; c++) begin
      if (axis_block_sigs[c]) begin
        snap_new[2*c +: 2] = found ? 2'b01 : 2'b11;
        found              = 1'b1;
      end
    end
  end

  //---------------------------------------------------------------------------
  // Next-state logic.
  //
  // clear is checked first, so it overrides an entry to BLOCKED on the same
  // edge.
  //---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;

    if (clear) begin
      state_d = ST_IDLE;
      run_d   = '0;
      cnt_d   = '0;
      snap_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          run_d = '0;
          if (stop_now) begin
            if (CONFIRM_CYCLES == 1) begin
              state_d = ST_BLOCKED;
              snap_d  = snap_new;
            end else begin
              state_d = ST_PENDING;
              run_d   = RUN_W'(1);
            end
          end
        end

        ST_PENDING: begin
          if (!stop_now) begin
            // A single running cycle forfeits all accumulated credit.
            state_d = ST_IDLE;
            run_d   = '0;
          end else if (run_q == RUN_W'(CONFIRM_CYCLES - 1)) begin
            state_d = ST_BLOCKED;
            run_d   = '0;
            snap_d  = snap_new;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end

        ST_BLOCKED: begin
          if (!STICKY && !stop_now) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            snap_d  = '0;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          run_d   = '0;
          cnt_d   = '0;
          snap_d  = '0;
        end
      endcase
    end

    block_d = (state_d == ST_BLOCKED);
  end

  //---------------------------------------------------------------------------
  // State registers.
  //---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge values and simulation matches the hardware.
    if (reset) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      cnt_q   <= '0;
      // NOTE: the snapshot is a handful of flops, not a memory array. It is
      // reset along with everything else, so a stale culprit can never leak
      // out after reset.
      snap_q  <= '0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      block_q <= block_d;
    end
  end

  //---------------------------------------------------------------------------
  // Outputs: registered values only.
  //---------------------------------------------------------------------------
  assign block           = block_q;
  assign stall_cnt       = cnt_q;
  assign axis_block_info = block_q ? snap_q : '0;

endmodule

// File: tb/tb_aesl_deadlock_monitor_param.sv
//-----------------------------------------------------------------------------
// Testbench for aesl_deadlock_monitor_param.
//
// Four parameterisations run side by side. They share one clock and one reset:
//   u0 : defaults (CONFIRM_CYCLES=1, STICKY=1)
//   u1 : CONFIRM_CYCLES=4
//   u2 : STICKY=0
//   u3 : NUM_PROC=8, NUM_AXIS=4, CNT_W=4; channel 2 maps out of range
//
// Stimulus pushes the expected output for the following cycle into a queue.
// A monitor on the falling edge pops each entry and compares it in its
// scheduled cycle.
//-----------------------------------------------------------------------------
module tb_aesl_deadlock_monitor_param;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  //---------------------------------------------------------------------------
  // Per-instance stimulus and response signals.
  //---------------------------------------------------------------------------
  logic       c0 = 0, c1 = 0, c2 = 0, c3 = 0;
  logic [1:0] ab0 = '0, ab1 = '0, ab2 = '0;
  logic [4:0] ii0 = '0, ib0 = '0, ii1 = '0, ib1 = '0, ii2 = '0, ib2 = '0;
  logic [3:0] ab3 = '0;
  logic [7:0] ii3 = '0, ib3 = '0;

  logic [3:0]  info0, info1, info2;
  logic [7:0]  info3;
  logic        blk0, blk1, blk2, blk3;
  logic [15:0] cnt0, cnt1, cnt2;
  logic [3:0]  cnt3;

  //---------------------------------------------------------------------------
  // DUT instances.
  //---------------------------------------------------------------------------
  aesl_deadlock_monitor_param u0 (
    .clock(clock), .reset(reset), .clear(c0), .axis_block_sigs(ab0),
    .inst_idle_sigs(ii0), .inst_block_sigs(ib0),
    .axis_block_info(info0), .block(blk0), .stall_cnt(cnt0));

  aesl_deadlock_monitor_param #(.CONFIRM_CYCLES(4)) u1 (
    .clock(clock), .reset(reset), .clear(c1), .axis_block_sigs(ab1),
    .inst_idle_sigs(ii1), .inst_block_sigs(ib1),
    .axis_block_info(info1), .block(blk1), .stall_cnt(cnt1));

  aesl_deadlock_monitor_param #(.STICKY(1'b0)) u2 (
    .clock(clock), .reset(reset), .clear(c2), .axis_block_sigs(ab2),
    .inst_idle_sigs(ii2), .inst_block_sigs(ib2),
    .axis_block_info(info2), .block(blk2), .stall_cnt(cnt2));

  aesl_deadlock_monitor_param #(
    .NUM_PROC(8), .NUM_AXIS(4),
    .AXIS_PROC_MAP({8'd6, 8'd9, 8'd2, 8'd0}),
    .CNT_W(4)
  ) u3 (
    .clock(clock), .reset(reset), .clear(c3), .axis_block_sigs(ab3),
    .inst_idle_sigs(ii3), .inst_block_sigs(ib3),
    .axis_block_info(info3), .block(blk3), .stall_cnt(cnt3));

  //---------------------------------------------------------------------------
  // Scoreboard.
  //---------------------------------------------------------------------------
  typedef struct {
    int          dut;
    int          cyc;
    logic        blk;
    logic [7:0]  info;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   cycle_cnt = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Compare one DUT response against its expectation and update the counts.
  task automatic check(input string nm, input logic cyc_ok,
                       input logic ab, input logic [7:0] ai, input logic [15:0] ac,
                       input logic eb, input logic [7:0] ei, input logic [15:0] ec);
    n_tests++;
    if (!cyc_ok || ab !== eb || ai !== ei || ac !== ec) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got block=%0b info=%h cnt=%0d, expected block=%0b info=%h cnt=%0d%s",
               nm, cycle_cnt, ab, ai, ac, eb, ei, ec, cyc_ok ? "" : " (not compared in its cycle)");
    end
  endtask

  // Expect this response from DUT d after the next rising edge.
  task automatic expect_next(input int d, input logic b, input logic [7:0] i,
                             input logic [15:0] c, input string nm);
    exp_t e;
    e.dut  = d;
    e.cyc  = cycle_cnt + 1;
    e.blk  = b;
    e.info = i;
    e.cnt  = c;
    e.nm   = nm;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  //---------------------------------------------------------------------------
  // Monitor: on the falling edge, pop and compare every entry due this cycle.
  //---------------------------------------------------------------------------
  exp_t        m_e;
  logic        m_b;
  logic [7:0]  m_i;
  logic [15:0] m_c;

  always @(negedge clock) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cycle_cnt) begin
      m_e = sb_q.pop_front();
      case (m_e.dut)
        0:       begin m_b = blk0; m_i = {4'b0, info0}; m_c = cnt0;          end
        1:       begin m_b = blk1; m_i = {4'b0, info1}; m_c = cnt1;          end
        2:       begin m_b = blk2; m_i = {4'b0, info2}; m_c = cnt2;          end
        default: begin m_b = blk3; m_i = info3;         m_c = {12'b0, cnt3}; end
      endcase
      check(m_e.nm, m_e.cyc == cycle_cnt, m_b, m_i, m_c, m_e.blk, m_e.info, m_e.cnt);
    end
  end

  //---------------------------------------------------------------------------
  // Directed stimulus.
  //---------------------------------------------------------------------------
  initial begin
    tick();
    tick();

    // Reset state of every instance.
    for (int d = 0; d < 4; d++) expect_next(d, 1'b0, 8'h00, 16'd0, "reset_state");
    tick();
    reset = 1'b0;

    // u0:
    //   - procs 0,2,3 idle; proc 4 FIFO-blocked; ch0 (-> proc1) blocked
    //     for one cycle.
    //   - Afterwards the region runs again. Sticky holds the block.
    ii0 = 5'b01101; ib0 = 5'b10000; ab0 = 2'b01;
    expect_next(0, 1'b1, 8'h03, 16'd0, "t1_entry");
    tick();
    ii0 = '0; ib0 = '0; ab0 = '0;
    expect_next(0, 1'b1, 8'h03, 16'd1, "t1_cnt1");
    tick();
    expect_next(0, 1'b1, 8'h03, 16'd2, "t1_sticky_cnt2");
    tick();
    expect_next(0, 1'b1, 8'h03, 16'd3, "t1_sticky_cnt3");
    tick();
    c0 = 1'b1;
    expect_next(0, 1'b0, 8'h00, 16'd0, "t1_clear");
    tick();
    c0 = 1'b0;
    expect_next(0, 1'b0, 8'h00, 16'd0, "t1_after_clear");
    tick();

    // u0: all processes idle with no AXIS block is never a deadlock.
    ii0 = 5'h1f;
    for (int k = 0; k < 100; k++) begin
      expect_next(0, 1'b0, 8'h00, 16'd0, "idle_no_axis");
      tick();
    end
    ii0 = '0;

    // u1 (CONFIRM_CYCLES=4):
    //   - 3 stalled cycles, then 1 running cycle, then 4 stalled cycles.
    //   - block must rise only after the 4th cycle of the second burst.
    ii1 = 5'b01101; ib1 = 5'b10000;
    for (int k = 0; k < 3; k++) begin
      ab1 = 2'b01;
      expect_next(1, 1'b0, 8'h00, 16'd0, "cc4_burst1");
      tick();
    end
    ab1 = 2'b00;
    expect_next(1, 1'b0, 8'h00, 16'd0, "cc4_gap");
    tick();
    for (int k = 0; k < 3; k++) begin
      ab1 = 2'b01;
      expect_next(1, 1'b0, 8'h00, 16'd0, "cc4_burst2_pre");
      tick();
    end
    expect_next(1, 1'b1, 8'h03, 16'd0, "cc4_confirm");
    tick();
    expect_next(1, 1'b1, 8'h03, 16'd1, "cc4_cnt1");
    tick();
    c1 = 1'b1; ab1 = '0; ii1 = '0; ib1 = '0;
    expect_next(1, 1'b0, 8'h00, 16'd0, "cc4_clear");
    tick();
    c1 = 1'b0;

    // u2 (STICKY=0):
    //   - both channels blocked; ch0 is primary, ch1 is secondary.
    //   - block drops on the edge after the stall ends.
    ii2 = 5'b01101; ab2 = 2'b11;
    expect_next(2, 1'b1, 8'h07, 16'd0, "nsticky_entry");
    tick();
    expect_next(2, 1'b1, 8'h07, 16'd1, "nsticky_hold");
    tick();
    ii2 = '0; ab2 = '0;
    expect_next(2, 1'b0, 8'h00, 16'd0, "nsticky_drop");
    tick();
    expect_next(2, 1'b0, 8'h00, 16'd0, "nsticky_idle");
    tick();

    // u3:
    //   - ch1 -> proc2 and ch3 -> proc6 blocked; all other processes idle.
    //   - The 4-bit counter saturates at 15.
    ii3 = 8'b1011_1011; ab3 = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      expect_next(3, 1'b1, 8'b01_00_11_00, (k > 15) ? 16'd15 : 16'(k), "wide_sat");
      tick();
    end
    c3 = 1'b1;
    expect_next(3, 1'b0, 8'h00, 16'd0, "wide_clear");
    tick();
    c3 = 1'b0;

    // u3: ch2 maps to process 9, which does not exist, so ch2 is ignored.
    ab3 = 4'b0100; ii3 = 8'hff;
    for (int k = 0; k < 3; k++) begin
      expect_next(3, 1'b0, 8'h00, 16'd0, "unmapped_chan");
      tick();
    end
    ab3 = '0; ii3 = '0;

    // u0: clear on the same edge as the entry to BLOCKED. clear wins, and
    // counting restarts on the next stalled cycle.
    ii0 = 5'b01101; ib0 = 5'b10000; ab0 = 2'b01; c0 = 1'b1;
    expect_next(0, 1'b0, 8'h00, 16'd0, "clear_beats_entry");
    tick();
    c0 = 1'b0;
    expect_next(0, 1'b1, 8'h03, 16'd0, "restart_after_clear");
    tick();
    expect_next(0, 1'b1, 8'h03, 16'd1, "restart_cnt1");
    tick();

    // u0: reset asserted while BLOCKED, with the stall still present.
    reset = 1'b1;
    expect_next(0, 1'b0, 8'h00, 16'd0, "reset_mid_blocked");
    tick();
    reset = 1'b0; ii0 = '0; ib0 = '0; ab0 = '0;
    expect_next(0, 1'b0, 8'h00, 16'd0, "after_reset");
    tick();

    // Let the monitor drain. Anything still queued was never compared.
    tick();
    tick();
    while (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      check(m_e.nm, 1'b0, 1'bx, 8'hxx, 16'hxxxx, m_e.blk, m_e.info, m_e.cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected the stimulus to finish");
    $fatal(1);
  end

endmodule
